mod_exp_ctrl: RTL and testbench

//  Left-to-right square-and-multiply sequencer computing result = base^exponent mod m.

---
 rtl/mod_exp_ctrl.sv | 155 +++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exponent mod m.
// Drives one external modular multiplier, one operation at a time.
module mod_exp_ctrl #(
  parameter int unsigned NBITS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [NBITS-1:0] exponent,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             busy,
  output logic             done_irq_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_b,
  output logic [NBITS-1:0] mul_m,
  output logic             mul_enable_p,
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_p
);

  localparam int unsigned CW = $clog2(NBITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SQR_ISSUE,
    S_SQR_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_r;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_e;
  logic [CW-1:0]    r_cnt;
  logic [NBITS-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic [NBITS-1:0] r_mul_a;
  logic [NBITS-1:0] r_mul_b;
  logic [NBITS-1:0] r_mul_m;
  logic             r_mul_en;

  logic             w_msb;
  logic             w_last;
  logic [NBITS-1:0] w_e_shl;
  logic [CW-1:0]    w_cnt_dec;
  logic [NBITS-1:0] w_zero_exp_val;
  logic             w_adv;
  logic [NBITS-1:0] w_adv_val;

  assign w_msb          = r_e[NBITS-1];
  assign w_last         = (r_cnt == CW'(1));
  assign w_e_shl        = {r_e[NBITS-2:0], 1'b0};
  assign w_cnt_dec      = r_cnt - CW'(1);
  assign w_zero_exp_val = (r_mul_m == NBITS'(1)) ? {NBITS{1'b0}} : NBITS'(1);

  // Current exponent bit fully processed: move on to the next bit or finish.
  assign w_adv = ((r_state == S_SCAN) && w_msb) ||
                 ((r_state == S_SQR_WAIT) && mul_done_p && !w_msb) ||
                 ((r_state == S_MUL_WAIT) && mul_done_p);
  assign w_adv_val = (r_state == S_SCAN) ? r_b : mul_y;

  // Launch outputs are registered on entry to an ISSUE state so the pulse
  // coincides with the ISSUE cycle itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_r      <= '0;
      r_b      <= '0;
      r_e      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_mul_m  <= '0;
      r_mul_en <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_mul_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_p) begin
            r_b     <= base;
            r_e     <= exponent;
            r_mul_m <= m;
            r_cnt   <= CW'(NBITS);
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_msb) begin
            r_e   <= w_e_shl;
            r_cnt <= w_cnt_dec;
            if (w_last) begin
              r_r      <= w_zero_exp_val;
              r_result <= w_zero_exp_val;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_SQR_ISSUE: r_state <= S_SQR_WAIT;
        S_SQR_WAIT: begin
          if (mul_done_p && w_msb) begin
            r_r      <= mul_y;
            r_mul_a  <= mul_y;
            r_mul_b  <= r_b;
            r_mul_en <= 1'b1;
            r_state  <= S_MUL_ISSUE;
          end
        end
        S_MUL_ISSUE: r_state <= S_MUL_WAIT;
        S_MUL_WAIT: ;
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_adv) begin
        r_r   <= w_adv_val;
        r_e   <= w_e_shl;
        r_cnt <= w_cnt_dec;
        if (w_last) begin
          r_result <= w_adv_val;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end else begin
          r_mul_a  <= w_adv_val;
          r_mul_b  <= w_adv_val;
          r_mul_en <= 1'b1;
          r_state  <= S_SQR_ISSUE;
        end
      end
    end
  end

  assign result       = r_result;
  assign busy         = r_busy;
  assign done_irq_p   = r_done;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign mul_m        = r_mul_m;
  assign mul_enable_p = r_mul_en;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Randomized bench for mod_exp_ctrl with a behavioural multiplier and a
// software modpow / op-sequence / latency reference.
module tb_mod_exp_ctrl;

  localparam int unsigned NB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_p;
  logic [NB-1:0] base, exponent, m;
  logic [NB-1:0] result;
  logic          busy, done_irq_p;
  logic [NB-1:0] mul_a, mul_b, mul_m, mul_y;
  logic          mul_enable_p, mul_done_p;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  int              lat_l = 1;
  logic [2*NB-1:0] exp_ops[$];
  bit              outst = 1'b0;
  int              cd    = 0;
  int              n_ops = 0;
  logic [NB-1:0]   cap_a, cap_b, cap_m;

  mod_exp_ctrl #(.NBITS(NB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_p     (start_p),
    .base        (base),
    .exponent    (exponent),
    .m           (m),
    .result      (result),
    .busy        (busy),
    .done_irq_p  (done_irq_p),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_m       (mul_m),
    .mul_enable_p(mul_enable_p),
    .mul_y       (mul_y),
    .mul_done_p  (mul_done_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic longint unsigned ref_modpow(input longint unsigned b,
                                                 input longint unsigned e,
                                                 input longint unsigned mm);
    longint unsigned r, x;
    r = 1 % mm;
    x = b % mm;
    while (e != 0) begin
      if (e[0]) r = (r * x) % mm;
      x = (x * x) % mm;
      e = e >> 1;
    end
    return r;
  endfunction

  // Behavioural multiplier: fixed latency lat_l from enable to done, checks protocol.
  initial begin : mul_model
    logic [2*NB-1:0] op;
    mul_done_p = 1'b0;
    mul_y      = '0;
    forever begin
      @(posedge clk);
      #2;
      mul_done_p = 1'b0;
      if (!rst_n) begin
        outst = 1'b0;
        exp_ops.delete();
      end else begin
        if (mul_enable_p) check("enable_while_outstanding", 64'(outst), 64'd0);
        if (outst) begin
          cd--;
          if (cd == 0) begin
            check("operand_stability", {16'd0, mul_a, mul_b, mul_m}, {16'd0, cap_a, cap_b, cap_m});
            mul_y      = (cap_m == 0) ? '0 : NB'((64'(cap_a) * 64'(cap_b)) % 64'(cap_m));
            mul_done_p = 1'b1;
            outst      = 1'b0;
          end
        end
        if (mul_enable_p) begin
          n_ops++;
          if (exp_ops.size() > 0) begin
            op = exp_ops.pop_front();
            check("op_operands", 64'({mul_a, mul_b}), 64'(op));
          end
          cap_a = mul_a;
          cap_b = mul_b;
          cap_m = mul_m;
          outst = 1'b1;
          cd    = lat_l;
        end
      end
    end
  end

  task automatic run_case(input logic [NB-1:0] b, input logic [NB-1:0] e,
                          input logic [NB-1:0] mm, input bit repulse);
    longint unsigned r, exp_res;
    int k, w, exp_lat, exp_n;
    int unsigned t0;
    bit got;
    k = 0;
    w = 0;
    for (int i = 0; i < int'(NB); i++) begin
      if (e[i]) begin k = i; w++; end
    end
    exp_ops.delete();
    r = 64'(b);
    for (int i = k - 1; i >= 0; i--) begin
      exp_ops.push_back({NB'(r), NB'(r)});
      r = (r * r) % 64'(mm);
      if (e[i]) begin
        exp_ops.push_back({NB'(r), b});
        r = (r * 64'(b)) % 64'(mm);
      end
    end
    exp_n   = exp_ops.size();
    exp_res = ref_modpow(64'(b), 64'(e), 64'(mm));
    lat_l   = $urandom_range(1, 4);
    exp_lat = (w == 0) ? int'(NB) + 1
                       : (int'(NB) - k) + k * (lat_l + 1) + (w - 1) * (lat_l + 1) + 1;
    n_ops = 0;

    @(posedge clk); #1;
    base = b; exponent = e; m = mm; start_p = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start_p  = 1'b0;
    base     = NB'($urandom);
    exponent = NB'($urandom);
    m        = NB'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_irq_p) begin got = 1'b1; break; end
      if (repulse) start_p = (i == 3);
      @(posedge clk); #1;
    end
    start_p = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      check("latency", 64'(cyc - t0), 64'(exp_lat));
      check("result", 64'(result), exp_res);
      check("busy_in_done", 64'(busy), 64'd1);
      check("mul_op_count", 64'(n_ops), 64'(exp_n));
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done_irq_p), 64'd0);
      check("busy_fall", 64'(busy), 64'd0);
      check("result_hold", 64'(result), exp_res);
    end
  endtask

  task automatic reset_mid_op();
    bit found;
    int n_done;
    exp_ops.delete();
    exp_ops.push_back({16'd3, 16'd3});
    lat_l = 6;
    @(posedge clk); #1;
    base = 16'd3; exponent = 16'd5; m = 16'd7; start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (outst) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("reached_sqr_wait", 64'(found), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("busy_after_reset", 64'(busy), 64'd0);
    check("result_after_reset", 64'(result), 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_irq_p) n_done++;
      @(posedge clk); #1;
    end
    check("no_done_after_abort", 64'(n_done), 64'd0);
  endtask

  initial begin : main
    logic [NB-1:0] rm, rb, re, mask;
    rst_n = 1'b0; start_p = 1'b0; base = '0; exponent = '0; m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 64'(result), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done_irq_p), 64'd0);
    check("rst_mul_en", 64'(mul_enable_p), 64'd0);
    check("rst_mul_ops", 64'({mul_a, mul_b, mul_m}), 64'd0);
    rst_n = 1'b1;

    run_case(16'd3, 16'd5, 16'd7, 1'b0);
    run_case(16'd4, 16'd13, 16'd497, 1'b0);
    run_case(16'd7, 16'd1, 16'd11, 1'b0);
    run_case(16'd9, 16'd0, 16'd497, 1'b0);
    run_case(16'd0, 16'd0, 16'd1, 1'b0);
    run_case(16'd2, 16'hFFFF, 16'hFFF1, 1'b0);
    run_case(16'd5, 16'h8001, 16'd1000, 1'b0);
    run_case(16'd4, 16'd13, 16'd497, 1'b1);
    reset_mid_op();
    run_case(16'd3, 16'd5, 16'd7, 1'b0);

    for (int n = 0; n < 25; n++) begin
      rm   = (n % 8 == 7) ? 16'd1 : NB'($urandom_range(2, 65535));
      rb   = NB'($urandom % 32'(rm));
      mask = 16'hFFFF >> $urandom_range(0, 15);
      re   = NB'($urandom) & mask;
      run_case(rb, re, rm, (n % 5 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
